noobs_io_subsys: RTL

Parametrised memory-mapped I/O subsystem for NoobsCPU SoCs. It replaces the single-bit LED register and the unbuffered UART TX path with:
- an N-bit GPIO output port with write and toggle access,
- a FIFO-buffered 8N1 UART transmitter with a programmable baud divisor,
- a readable status register.
It sits on the CPU data bus (m_addr/m_wr/m_rd/m_en) beside data_mem, and the SoC muxes its read data in when io_hit is high.

---
 rtl/noobs_io_subsys.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/noobs_io_subsys.sv
// rtl/noobs_io_subsys.sv - NoobsCPU memory-mapped GPIO, buffered 8N1 UART TX and status block
//
// Ports:
//   clk        block clock (CPU clock)
//   reset_     asynchronous active-low reset
//   m_addr     CPU data address
//   m_wr_data  CPU write data
//   m_wr       write strobe
//   m_rd       read strobe
//   m_en       bus enable
//   rd_data    read data, combinational from m_addr (zero outside the decoded window)
//   io_hit     m_en and m_addr inside BASE_ADDR..BASE_ADDR+3
//   gpio       registered GPIO outputs
//   uart_tx    serial output, idle high
//
// Register map (offset from BASE_ADDR):
//   +0 GPIO    write: gpio = data      read: gpio zero-extended
//   +1 TX      write: push into FIFO   read: {4'b0, overflow, shifter_active, fifo_empty, fifo_full}
//   +2 DIV     baud divisor, one bit lasts DIV+1 cycles
//   +3 TOGGLE  write: gpio ^= data     read: 0
module noobs_io_subsys #(
    parameter logic [10:0] BASE_ADDR   = 11'd100,
    parameter int          GPIO_W      = 8,
    parameter logic [7:0]  GPIO_RESET  = 8'd1,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [7:0]  DEFAULT_DIV = 8'd15
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [10:0]       m_addr,
    input  logic [7:0]        m_wr_data,
    input  logic              m_wr,
    input  logic              m_rd,
    input  logic              m_en,
    output logic [7:0]        rd_data,
    output logic              io_hit,
    output logic [GPIO_W-1:0] gpio,
    output logic              uart_tx
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Address decode. The subtraction is done one bit wider so that addresses
    // below BASE_ADDR land far above the window instead of wrapping into it.
    logic [11:0] addr_diff;
    logic        addr_match;
    logic [1:0]  reg_sel;
    logic        wr_hit;
    logic        rd_hit;

    assign addr_diff  = {1'b0, m_addr} - {1'b0, BASE_ADDR};
    assign addr_match = (addr_diff < 12'd4);
    assign reg_sel    = addr_diff[1:0];
    assign io_hit     = m_en & addr_match;
    assign wr_hit     = io_hit & m_wr;
    assign rd_hit     = io_hit & m_rd;

    // Registers and FIFO state
    logic [7:0]    divisor;
    logic          overflow;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;

    // Transmitter state
    tx_state_t  state;
    tx_state_t  next_state;
    logic [7:0] shift_reg;
    logic [7:0] bit_cnt;
    logic [2:0] idx;
    logic       bit_end;
    logic       shifter_active;

    assign fifo_full      = (count == FULL_CNT);
    assign fifo_empty     = (count == '0);
    assign push_req       = wr_hit & (reg_sel == 2'd1);
    // Fullness is judged on the registered count, so a push while full is
    // dropped even when the shifter pops in the same cycle.
    assign push           = push_req & ~fifo_full;
    assign pop            = (state == IDLE) & ~fifo_empty;
    assign bit_end        = (bit_cnt == 8'd0);
    assign shifter_active = (state != IDLE);

    // GPIO, divisor and overflow flag
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            gpio     <= GPIO_RESET[GPIO_W-1:0];
            divisor  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_hit && reg_sel == 2'd0) begin
                gpio <= m_wr_data[GPIO_W-1:0];
            end else if (wr_hit && reg_sel == 2'd3) begin
                gpio <= gpio ^ m_wr_data[GPIO_W-1:0];
            end
            if (wr_hit && reg_sel == 2'd2) begin
                divisor <= m_wr_data;
            end
            // A dropped push wins over a status read in the same cycle so the
            // loss is never silently cleared.
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (rd_hit && reg_sel == 2'd1) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= m_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // TX FSM: next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty)              next_state = START;
            START:   if (bit_end)                  next_state = DATA;
            DATA:    if (bit_end && idx == 3'd7)   next_state = STOP;
            STOP:    if (bit_end)                  next_state = IDLE;
            default:                               next_state = IDLE;
        endcase
    end

    // TX FSM: output logic. Combinational from state so that an asynchronous
    // reset forces the line idle without waiting for a clock.
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            IDLE:    uart_tx = 1'b1;
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_reg[idx];
            STOP:    uart_tx = 1'b1;
            default: uart_tx = 1'b1;
        endcase
    end

    // Bit timing datapath. bit_cnt is reloaded from the live divisor at each
    // bit boundary, so a divisor write only affects bits that start later.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            shift_reg <= 8'd0;
            bit_cnt   <= 8'd0;
            idx       <= 3'd0;
        end else if (state == IDLE) begin
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                bit_cnt   <= divisor;
            end
        end else if (bit_end) begin
            bit_cnt <= divisor;
            if (state == START) begin
                idx <= 3'd0;
            end else if (state == DATA) begin
                idx <= idx + 3'd1;
            end
        end else begin
            bit_cnt <= bit_cnt - 8'd1;
        end
    end

    // Read mux
    always_comb begin
        rd_data = 8'd0;
        if (addr_match) begin
            case (reg_sel)
                2'd0:    rd_data = 8'(gpio);
                2'd1:    rd_data = {4'b0000, overflow, shifter_active, fifo_empty, fifo_full};
                2'd2:    rd_data = divisor;
                default: rd_data = 8'd0;
            endcase
        end
    end

endmodule
